serializer_mlane: RTL and testbench

//  Parametrised multi-lane successor of the single-bit serializer. Accepts WIDTH-bit

---
 rtl/serializer_mlane.sv | 160 ++++++++++++++++
 tb/tb_serializer_mlane.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/serializer_mlane.sv
// serializer_mlane: WIDTH-bit words shifted out over LANES lanes, one-word hold buffer.
// Define SERDES_PARITY_EN to append an even-parity beat after every word.
module serializer_mlane #(
    parameter int WIDTH     = 8,
    parameter int LANES     = 1,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic [LANES-1:0] o_data,
    output logic             o_frame,
    output logic             o_sof,
    output logic             o_busy
);
    localparam int BEATS = WIDTH / LANES;
    localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    if ((LANES < 1) || (LANES > WIDTH) || (WIDTH % LANES != 0)) begin : g_bad_cfg
        $error("serializer_mlane: WIDTH must be a positive multiple of LANES");
    end

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PAR
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    beat_q, beat_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [LANES-1:0] data_q, data_d;
    logic             frame_q, frame_d;
    logic             sof_q, sof_d;
`ifdef SERDES_PARITY_EN
    logic             par_q, par_d;
`endif

    logic             at_end;
    logic             last;
    logic             xfer;
    logic             acc;
    logic             idle_or_last;
    logic             start;
    logic             hold_wr;
    logic [WIDTH-1:0] word_new;

    // Slice presented on the next beat, and the word with that slice consumed.
    function automatic logic [LANES-1:0] head(input logic [WIDTH-1:0] w);
        if (MSB_FIRST) return w[WIDTH-1 -: LANES];
        return w[LANES-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] adv(input logic [WIDTH-1:0] w);
        if (MSB_FIRST) return w << LANES;
        return w >> LANES;
    endfunction

    always_comb begin
        at_end = (state_q == SHIFT) && (beat_q == LAST_BEAT);
`ifdef SERDES_PARITY_EN
        last = (state_q == PAR);
`else
        last = at_end;
`endif
        xfer         = last && hold_full_q;
        o_ready      = !hold_full_q || xfer;
        acc          = i_valid && o_ready;
        idle_or_last = (state_q == IDLE) || last;
        start        = idle_or_last && (hold_full_q || acc);
        word_new     = hold_full_q ? hold_q : i_data;
        // An accepted word bypasses the hold only when the shifter frees up now.
        hold_wr      = acc && !(idle_or_last && !hold_full_q);
    end

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        shreg_d     = shreg_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        data_d      = '0;
        frame_d     = 1'b0;
        sof_d       = 1'b0;
`ifdef SERDES_PARITY_EN
        par_d       = par_q;
`endif
        if (hold_wr) begin
            hold_d      = i_data;
            hold_full_d = 1'b1;
        end else if (xfer) begin
            hold_full_d = 1'b0;
        end

        if (start) begin
            state_d = SHIFT;
            beat_d  = '0;
            data_d  = head(word_new);
            shreg_d = adv(word_new);
            frame_d = 1'b1;
            sof_d   = 1'b1;
`ifdef SERDES_PARITY_EN
            par_d   = ^word_new;
`endif
        end else if ((state_q == SHIFT) && !at_end) begin
            beat_d  = beat_q + CW'(1);
            data_d  = head(shreg_q);
            shreg_d = adv(shreg_q);
            frame_d = 1'b1;
`ifdef SERDES_PARITY_EN
        end else if (at_end) begin
            state_d = PAR;
            data_d  = LANES'(par_q);
            frame_d = 1'b1;
`endif
        end else begin
            state_d = IDLE;
            beat_d  = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            shreg_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            data_q      <= '0;
            frame_q     <= 1'b0;
            sof_q       <= 1'b0;
`ifdef SERDES_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            shreg_q     <= shreg_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            data_q      <= data_d;
            frame_q     <= frame_d;
            sof_q       <= sof_d;
`ifdef SERDES_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    assign o_data  = data_q;
    assign o_frame = frame_q;
    assign o_sof   = sof_q;
    assign o_busy  = (state_q != IDLE) || hold_full_q;

endmodule

// File: tb/tb_serializer_mlane.sv
// tb_serializer_mlane: scoreboard bench over three lane configurations of serializer_mlane.
// Expected beats are scheduled per word from slice arithmetic and a word-timing model.
module tb_serializer_mlane;
    localparam int WIDTH = 8;
`ifdef SERDES_PARITY_EN
    localparam int PBIT = 1;
`else
    localparam int PBIT = 0;
`endif

    logic clk = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input int lanes, input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL L%0d %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     lanes, nm, act, exp, cyc);
        end
    endtask

    typedef struct {
        int at;
        int data;
        bit sof;
    } beat_t;

    for (genvar g = 0; g < 3; g++) begin : g_blk
        localparam int L = (g == 0) ? 1 : ((g == 1) ? 2 : 8);
        localparam bit M = (g == 1) ? 1'b0 : 1'b1;
        localparam int BEATS = WIDTH / L;
        localparam int P = BEATS + PBIT;

        logic             rst_n;
        logic             valid;
        logic             ready;
        logic [WIDTH-1:0] data;
        logic [L-1:0]     odata;
        logic             frame;
        logic             sof;
        logic             busy;

        beat_t q[$];
        int    last_start = -100;
        int    prev_end = -100;
        bit    done = 1'b0;

        serializer_mlane #(
            .WIDTH(WIDTH),
            .LANES(L),
            .MSB_FIRST(M)
        ) dut (
            .i_clk  (clk),
            .i_rst_n(rst_n),
            .i_valid(valid),
            .o_ready(ready),
            .i_data (data),
            .o_data (odata),
            .o_frame(frame),
            .o_sof  (sof),
            .o_busy (busy)
        );

        function automatic int slice(input int w, input int b);
            int sh;
            sh = M ? (WIDTH - (b + 1) * L) : (b * L);
            return (w >> sh) & ((1 << L) - 1);
        endfunction

        // A word accepted at the edge closing cycle acc_cyc starts right after
        // both that edge and the previous word's final beat.
        task automatic push_word(input int w, input int acc_cyc);
            int st;
            st = (acc_cyc + 1 > prev_end + 1) ? acc_cyc + 1 : prev_end + 1;
            for (int b = 0; b < BEATS; b++) q.push_back('{st + b, slice(w, b), b == 0});
            if (PBIT != 0) q.push_back('{st + BEATS, $countones(w) % 2, 1'b0});
            last_start = st;
            prev_end = st + P - 1;
        endtask

        always @(negedge clk) begin
            beat_t e;
            int    exp_frame;
            if (!rst_n) begin
                q.delete();
                last_start = -100;
                prev_end = -100;
                chk(L, "reset o_data", int'(odata), 0);
                chk(L, "reset o_frame", int'(frame), 0);
                chk(L, "reset o_sof", int'(sof), 0);
                chk(L, "reset o_busy", int'(busy), 0);
            end else begin
                chk(L, "o_ready", int'(ready), int'(last_start <= cyc + 1));
                chk(L, "o_busy", int'(busy), int'(prev_end >= cyc));
                exp_frame = int'(q.size() > 0 && q[0].at == cyc);
                chk(L, "o_frame", int'(frame), exp_frame);
                if (frame && q.size() > 0) begin
                    e = q.pop_front();
                    chk(L, "beat cycle", cyc, e.at);
                    chk(L, "o_data", int'(odata), e.data);
                    chk(L, "o_sof", int'(sof), int'(e.sof));
                end else if (!frame) begin
                    chk(L, "idle o_data", int'(odata), 0);
                    chk(L, "idle o_sof", int'(sof), 0);
                    if (exp_frame != 0) void'(q.pop_front());
                end
                if (valid && ready) push_word(int'(data), cyc);
            end
        end

        task automatic send(input logic [WIDTH-1:0] w);
            int n;
            n = 0;
            valid = 1'b1;
            data = w;
            forever begin
                @(negedge clk);
                if (ready) break;
                n++;
                if (n > 64) begin
                    chk(L, "accept timeout", n, 0);
                    break;
                end
            end
            @(posedge clk);
            #1;
            valid = 1'b0;
            data = WIDTH'($urandom);
        endtask

        task automatic idle(input int n);
            valid = 1'b0;
            repeat (n) @(posedge clk);
            #1;
        endtask

        initial begin
            rst_n = 1'b1;
            valid = 1'b0;
            data = '0;
            #1 rst_n = 1'b0;
            repeat (3) @(posedge clk);
            #1 rst_n = 1'b1;
            send(8'h18);
            send(8'hE7);
            idle(2 * P + 4);
            send(8'h18);
            idle(P + 3);
            send(8'h19);
            idle(P + 3);
            send(8'hA5);
            idle(P + 3);
            send(8'h00);
            send(8'hFF);
            send(8'h5A);
            idle(2 * P + 4);
            // Reset lands mid-word with the next word waiting in the hold.
            send(8'h18);
            valid = 1'b1;
            data = 8'hE7;
            repeat (3) @(posedge clk);
            #1 rst_n = 1'b0;
            valid = 1'b0;
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
            idle(P + 4);
            for (int i = 0; i < 40; i++) begin
                if ($urandom_range(0, 2) == 0) idle($urandom_range(0, P + 2));
                send(WIDTH'($urandom));
            end
            idle(2 * P + 6);
            chk(L, "scoreboard drained", q.size(), 0);
            done = 1'b1;
        end
    end

    initial begin
        int t;
        t = 0;
        while (!(g_blk[0].done && g_blk[1].done && g_blk[2].done) && t < 20000) begin
            @(posedge clk);
            t++;
        end
        chk(0, "all blocks done",
            int'(g_blk[0].done && g_blk[1].done && g_blk[2].done), 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
